cpu_ctrl: RTL and testbench

Central sequencer for the simple RISC CPU. It walks every instruction through a fixed 8-cycle machine cycle (S0..S7) and drives the register and bus strobes:
- load_ir to the instruction register, which captures two bytes on two consecutive load_ir cycles;
- inc_pc/load_pc to the program counter, load_acc to the accumulator;
- rd/wr/datactl_ena to memory and the data bus.

It also owns HLT handling and a retired-instruction counter used by the bench.

---
 rtl/cpu_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Eight-cycle instruction sequencer for the simple RISC CPU.
// Drives the IR, PC, ACC and memory strobes. Also handles HLT and keeps a retired-instruction counter.
//
// state  | meaning
// S0     | fetch high instruction byte (rd, load_ir)
// S1     | fetch low instruction byte (rd, load_ir, inc_pc)
// S2     | idle, opcode becomes valid
// S3     | inc_pc, sample zero flag, branch to HALTED on HLT
// S4     | operand phase: ALU read / STO drive / JMP load
// S5     | execute: ACC load, memory write, JMP load, SKZ skip
// S6     | STO bus hold, SKZ second skip increment
// S7     | idle, instruction retires on exit
// HALTED | halt held until resume
module cpu_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             resume,
  output logic             load_ir,
  output logic             inc_pc,
  output logic             load_pc,
  output logic             load_acc,
  output logic             rd,
  output logic             wr,
  output logic             datactl_ena,
  output logic             halt,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] ret_cnt
);

  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    HALTED = 4'd8
  } state_e;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Strobe vector order: load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt
  typedef struct packed {
    logic load_ir;
    logic inc_pc;
    logic load_pc;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } strobe_t;

  state_e           state_q, state_d;
  logic             parked_q, parked_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  strobe_t          stb_q, stb_d;

  function automatic strobe_t decode(input state_e st, input logic [2:0] op, input logic z);
    strobe_t s;
    logic    alu;
    logic    skz_taken;
    s         = '0;
    alu       = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    skz_taken = (op == OP_SKZ) && z;
    case (st)
      S0: begin
        s.rd      = 1'b1;
        s.load_ir = 1'b1;
      end
      S1: begin
        s.rd      = 1'b1;
        s.load_ir = 1'b1;
        s.inc_pc  = 1'b1;
      end
      S3: s.inc_pc = 1'b1;
      S4: begin
        s.rd          = alu;
        s.datactl_ena = (op == OP_STO);
        s.load_pc     = (op == OP_JMP);
      end
      S5: begin
        s.rd          = alu;
        s.load_acc    = alu;
        s.datactl_ena = (op == OP_STO);
        s.wr          = (op == OP_STO);
        s.load_pc     = (op == OP_JMP);
        s.inc_pc      = skz_taken;
      end
      S6: begin
        s.datactl_ena = (op == OP_STO);
        s.inc_pc      = skz_taken;
      end
      HALTED: s.halt = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    parked_d = parked_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    stb_d    = '0;
    if (state_q == HALTED) begin
      if (resume) begin
        state_d  = S0;
        parked_d = 1'b0;
      end
    end else if (!ena) begin
      state_d  = S0;
      parked_d = 1'b1;
    end else if (parked_q) begin
      // Parked S0 shows no strobes; the first enabled edge starts the real S0 fetch.
      state_d  = S0;
      parked_d = 1'b0;
    end else begin
      case (state_q)
        S3: begin
          zero_d = zero;
          if (opcode == OP_HLT) begin
            state_d = HALTED;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            state_d = S4;
          end
        end
        S7: begin
          state_d = S0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        default: state_d = state_e'(state_q + 4'd1);
      endcase
    end
    if ((state_q == HALTED) || ena) begin
      stb_d = decode(state_d, opcode, zero_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S0;
      parked_q <= 1'b1;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      stb_q    <= '0;
    end else begin
      state_q  <= state_d;
      parked_q <= parked_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      stb_q    <= stb_d;
    end
  end

  assign load_ir     = stb_q.load_ir;
  assign inc_pc      = stb_q.inc_pc;
  assign load_pc     = stb_q.load_pc;
  assign load_acc    = stb_q.load_acc;
  assign rd          = stb_q.rd;
  assign wr          = stb_q.wr;
  assign datactl_ena = stb_q.datactl_ena;
  assign halt        = stb_q.halt;
  assign state       = state_q;
  assign ret_cnt     = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: per-cycle expected state/strobes/count are queued
// as each instruction is driven and compared one cycle at a time.
module tb_cpu_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, ena, zero, resume;
  logic [2:0]       opcode;
  logic             load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
  logic [3:0]       state;
  logic [CNT_W-1:0] ret_cnt;

  always #5 clk = ~clk;

  cpu_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .opcode(opcode), .zero(zero), .resume(resume),
    .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
    .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt),
    .state(state), .ret_cnt(ret_cnt)
  );

  typedef struct packed {
    logic [3:0]       st;
    logic [7:0]       stb;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [7:0]       stb_obs;

  assign stb_obs = {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe table: {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt}
  function automatic logic [7:0] exp_stb(input int k, input logic [2:0] op, input logic z);
    logic alu;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    case (k)
      0: return 8'h88;
      1: return 8'hC8;
      3: return 8'h40;
      4: return alu ? 8'h08 : (op == 3'd6) ? 8'h02 : (op == 3'd7) ? 8'h20 : 8'h00;
      5: return alu ? 8'h18 : (op == 3'd6) ? 8'h06 : (op == 3'd7) ? 8'h20 :
                ((op == 3'd1) && z) ? 8'h40 : 8'h00;
      6: return (op == 3'd6) ? 8'h02 : ((op == 3'd1) && z) ? 8'h40 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic [7:0] stb, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.st  = st;
    e.stb = stb;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_state"}, 32'(state), 32'(e.st));
      chk({tag, "_strobes"}, 32'(stb_obs), 32'(e.stb));
      chk({tag, "_ret_cnt"}, 32'(ret_cnt), 32'(e.cnt));
    end
  endtask

  // abort_at: cycle at which ena drops (8 = never); rst_at: cycle after which reset hits (8 = never)
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input int abort_at, input int rst_at, input bit from_halt);
    opcode = op;
    zero   = z;
    for (int k = 0; k < 8; k++) begin
      if (k == abort_at) begin
        ena = 1'b0;
        push(4'd0, 8'h00, exp_cnt);
        step({tag, "_abort"});
        ena = 1'b1;
        return;
      end
      resume = (k == 0 && from_halt) || (k == 2);
      push(4'(k), exp_stb(k, op, z), exp_cnt);
      step(tag);
      resume = 1'b0;
      if (k == 4) zero = ~z;
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        chk({tag, "_rst_strobes"}, 32'(stb_obs), 32'd0);
        chk({tag, "_rst_state"}, 32'(state), 32'd0);
        chk({tag, "_rst_cnt"}, 32'(ret_cnt), 32'd0);
        rst_n = 1'b1;
        return;
      end
      if (op == 3'd0 && k == 3) begin
        exp_cnt = exp_cnt + 1'b1;
        for (int j = 0; j < 20; j++) begin
          ena = !(j >= 5 && j < 10);
          push(4'd8, 8'h01, exp_cnt);
          step({tag, "_halted"});
        end
        ena = 1'b1;
        return;
      end
    end
    exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    zero    = 1'b0;
    resume  = 1'b0;
    opcode  = 3'd0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", 32'(stb_obs), 32'd0);
    chk("reset_cnt", 32'(ret_cnt), 32'd0);
    rst_n = 1'b1;

    run_instr("add", 3'd2, 1'b0, 8, 8, 1'b0);
    run_instr("sto", 3'd6, 1'b0, 8, 8, 1'b0);
    run_instr("skz_t", 3'd1, 1'b1, 8, 8, 1'b0);
    run_instr("skz_n", 3'd1, 1'b0, 8, 8, 1'b0);
    run_instr("jmp", 3'd7, 1'b1, 8, 8, 1'b0);
    run_instr("and", 3'd3, 1'b1, 8, 8, 1'b0);
    run_instr("add_rst", 3'd2, 1'b0, 8, 5, 1'b0);
    run_instr("add_post", 3'd2, 1'b0, 8, 8, 1'b0);
    run_instr("hlt", 3'd0, 1'b0, 8, 8, 1'b0);
    run_instr("xor_res", 3'd4, 1'b0, 8, 8, 1'b1);
    run_instr("lda_abort", 3'd5, 1'b0, 4, 8, 1'b0);
    run_instr("hlt_ena0", 3'd0, 1'b0, 3, 8, 1'b0);
    for (int i = 0; i < 16; i++) begin
      run_instr("wrap", 3'(1 + (i % 7)), 1'(i % 2), 8, 8, 1'b0);
    end
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
